// File: rtl/popcnt_seq_if.sv
// Handshake bundle for the sequential popcount engine.
// Master drives words and abort; slave returns counts.
interface popcnt_seq_if #(
    parameter int WIDTH = 28
);
    localparam int NCHUNK = WIDTH / 7;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int CYC_W  = $clog2(NCHUNK + 1);

    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [CNT_W-1:0] out_count;
    logic [CYC_W-1:0] out_cycles;
    logic             out_ready;
    logic             busy;

    modport master (
        output clr,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count,
        input  out_cycles,
        input  busy
    );

    modport slave (
        input  clr,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count,
        output out_cycles,
        output busy
    );
endinterface

// File: rtl/popcnt_seq.sv
// Sequential population count: one 7:3 counter time-shared
// over the word, low chunk first, with early termination.
module pCntr_7_3 (
    input  logic [6:0] x_i,
    output logic [2:0] s_o
);
    logic s0, c0, s1, c1, s2, c2, s3, c3;

    // Full-adder tree: three weight-1 FAs, one weight-2 FA.
    assign {c0, s0} = x_i[0] + x_i[1] + x_i[2];
    assign {c1, s1} = x_i[3] + x_i[4] + x_i[5];
    assign {c2, s2} = s0 + s1 + x_i[6];
    assign {c3, s3} = c0 + c1 + c2;
    assign s_o = {c3, s3, s2};
endmodule

module popcnt_seq #(
    parameter int WIDTH = 28
) (
    input logic         clk,
    input logic         rst_n,
    popcnt_seq_if.slave bus
);
    localparam int NCHUNK = WIDTH / 7;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int CYC_W  = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       s;
    logic             last;

    pCntr_7_3 u_cntr (
        .x_i (sh_q[6:0]),
        .s_o (s)
    );

    always_comb begin
        sh_d  = sh_q >> 7;
        acc_d = acc_q + CNT_W'(s);
        cyc_d = cyc_q + CYC_W'(1);
        last  = (sh_d == '0)
             || (cyc_d == CYC_W'(NCHUNK));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cyc_q   <= '0;
        end else if (bus.clr) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cyc_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh_q    <= bus.in_data;
                        acc_q   <= '0;
                        cyc_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sh_q  <= sh_d;
                    acc_q <= acc_d;
                    cyc_q <= cyc_d;
                    if (last) state_q <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result registers are acc/cyc themselves; they
    // are frozen while the FSM sits in DONE.
    assign bus.in_ready   = (state_q == IDLE) && !bus.clr;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_count  = acc_q;
    assign bus.out_cycles = cyc_q;
endmodule

// File: doc/popcnt_seq.md
# popcnt_seq

Sequential population-count engine that time-shares a single 7:3 parallel counter (`pCntr_7_3`) across a wide input word. It accepts a word over a valid/ready handshake and feeds one 7-bit chunk per cycle to the counter, lowest chunk first. It accumulates the 3-bit partial counts and returns the total number of ones over a second valid/ready handshake. It sits ahead of the compressor-tree datapath as the low-area alternative to a fully parallel counter tree, and is the first sequenced consumer of the parallel-counter library.

## Interface
- `WIDTH`, 28, input word width; must be a multiple of 7 and at least 7.
- `NCHUNK`, WIDTH/7, derived (localparam), number of 7-bit chunks.
- `CNT_W`, clog2(WIDTH+1), derived (localparam), width of the result.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort; returns to IDLE and discards the operation in flight.
- `in_valid`  in  1  input word valid.
- `in_data`  in  WIDTH  word to count.
- `in_ready`  out  1  block can accept a word.
- `out_valid`  out  1  result valid.
- `out_count`  out  CNT_W  number of ones in the accepted word.
- `out_cycles`  out  clog2(NCHUNK+1)  number of RUN cycles used (1..NCHUNK).
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in RUN or DONE.

## Operation
- Internal state: a WIDTH-bit shift register `sh`, an accumulator `acc` (CNT_W), a cycle counter `cyc`, and a 2-bit FSM with states IDLE, RUN and DONE.
- One `pCntr_7_3` instance. Its input is `sh[6:0]` and its output S feeds the accumulator adder. No other counter instance is permitted.
- IDLE: `in_ready`=1. When `in_valid` is high: `sh`<=`in_data`, `acc`<=0, `cyc`<=0, and the FSM goes to RUN.
- RUN: each cycle `acc`<=`acc`+S, `sh`<=`sh`>>7 (zero fill), `cyc`<=`cyc`+1.
  - Go to DONE when the shifted value `sh>>7` is all zero (early termination), or when `cyc`+1 equals NCHUNK.
  - Otherwise stay in RUN.
- DONE: `out_valid`=1, `out_count`=`acc`, `out_cycles`=`cyc`. When `out_ready` is high, go to IDLE.
  - No input is accepted in the same cycle as the DONE→IDLE transition; `in_ready` stays 0 until the FSM is in IDLE.
- `clr` has priority over every transition. When `clr` is high the FSM goes to IDLE, and `acc`, `cyc` and `sh` are cleared on the next edge. A word offered while `clr` is high is not accepted (`in_ready` is forced to 0).
- Arithmetic: S is zero-extended to CNT_W. `acc` cannot overflow, because its maximum is WIDTH ≤ 2^CNT_W−1.
- `out_count` and `out_cycles` are registered and hold their value while `out_valid`=1 and `out_ready`=0.
- Reset values: FSM=IDLE, `sh`=0, `acc`=0, `cyc`=0, `in_ready`=1, `out_valid`=0, `out_count`=0, `out_cycles`=0, `busy`=0.
- Asserting reset at any point, including mid-RUN or mid-DONE, forces the reset values immediately, with no partial result.

## Timing
- Accept edge is E0. RUN occupies cycles E0+1 .. E0+k, where k = `out_cycles` and 1 ≤ k ≤ NCHUNK. `out_valid` rises after edge E0+k.
- k = index of the highest nonzero chunk + 1, with a minimum of 1 (an all-zero word takes 1 RUN cycle).
- Throughput: at most one word per k+2 cycles (accept, k RUN cycles, one or more DONE cycles).
- `in_ready` depends only on state and `clr`, never combinationally on `in_valid`. `out_valid` depends only on state.
- The counter path is combinational within one cycle: `sh[6:0]` → `pCntr_7_3` → adder → `acc` register.

## Test plan
- Reset then idle: `rst_n` low → `in_ready`=1, `out_valid`=0, `out_count`=0, `busy`=0. Release reset, apply no stimulus → outputs unchanged.
- WIDTH=28, in_data=0x0000000 → out_count=0 and out_cycles=1; `out_valid` high 2 edges after accept.
- in_data=0xFFFFFFF → out_count=28, out_cycles=4.
- in_data=0x8000000 → out_count=1, out_cycles=4. Then in_data=0x000007F → out_count=7, out_cycles=1. Then in_data=0x5A5A5A5 → out_count=14, out_cycles=4.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_valid`, `out_count` and `out_cycles` stable and `in_ready`=0 throughout. Raise `out_ready` for one cycle → IDLE, and the next word is accepted one cycle later.
- Abort/reset mid-RUN: accept 0xFFFFFFF, pulse `clr` in the 2nd RUN cycle → IDLE next edge, no `out_valid`, and the next word (0x0000003) yields out_count=2. Repeat with `rst_n` low in the 2nd RUN cycle → reset values immediately.
